circ_queue_ptr_ctrl: RTL and testbench

Head/tail pointer and occupancy controller for a DEPTH-entry circular queue such as an issue queue, ROB or store buffer. It drives the mod-DEPTH head and tail counters: increments on pop and push, a synchronous load of the tail on speculative rollback, and a synchronous clear on flush. It sits directly upstream of the queue storage and presents valid/ready handshakes to the producer and the consumer.

---
 rtl/circ_queue_ptr_ctrl_if.sv | 46 ++++
 rtl/circ_queue_ptr_ctrl.sv | 118 +++++++++++
 tb/tb_circ_queue_ptr_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/circ_queue_ptr_ctrl_if.sv
// Handshake and pointer bus of circ_queue_ptr_ctrl.
// Macro: CIRC_QUEUE_ALMOST_FULL_EN adds almost_full_o.
// master: producer/consumer side (drives push/pop/flush/restore requests).
// slave : the pointer controller (drives pointers, occupancy, status, strobes).
interface circ_queue_ptr_ctrl_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          push_valid_i;
    logic          push_ready_o;
    logic          pop_ready_i;
    logic          pop_valid_o;
    logic          flush_i;
    logic          restore_i;
    logic [PW-1:0] restore_tail_i;
    logic [PW-1:0] head_o;
    logic [PW-1:0] tail_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic          push_o;
    logic          pop_o;
`ifdef CIRC_QUEUE_ALMOST_FULL_EN
    logic          almost_full_o;
`endif

    modport master (
        output push_valid_i, pop_ready_i, flush_i, restore_i, restore_tail_i,
        input  push_ready_o, pop_valid_o, head_o, tail_o, count_o,
               full_o, empty_o, push_o, pop_o
`ifdef CIRC_QUEUE_ALMOST_FULL_EN
      , input  almost_full_o
`endif
    );

    modport slave (
        input  push_valid_i, pop_ready_i, flush_i, restore_i, restore_tail_i,
        output push_ready_o, pop_valid_o, head_o, tail_o, count_o,
               full_o, empty_o, push_o, pop_o
`ifdef CIRC_QUEUE_ALMOST_FULL_EN
      , output almost_full_o
`endif
    );
endinterface

// File: rtl/circ_queue_ptr_ctrl.sv
// Head/tail pointer and occupancy controller for a DEPTH-entry circular queue.
// Optional macro CIRC_QUEUE_ALMOST_FULL_EN: adds registered almost_full_o
// (count >= AF_THRESH) and simulation assertions on occupancy.
// Ports: clk_i, rst_ni (async, active-low), bus (circ_queue_ptr_ctrl_if.slave):
//   push_valid_i/push_ready_o, pop_ready_i/pop_valid_o handshakes,
//   flush_i, restore_i/restore_tail_i, head_o, tail_o, count_o, full_o, empty_o,
//   push_o/pop_o accept strobes (combinational).
module circ_queue_ptr_ctrl #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned INIT      = 0
`ifdef CIRC_QUEUE_ALMOST_FULL_EN
  , parameter int unsigned AF_THRESH = DEPTH - 2
`endif
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    circ_queue_ptr_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_c, pop_c;
    logic [CW-1:0] rt_ext, hd_ext;

    // Mod-DEPTH increment; explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next-state: flush > restore > push/pop.
    always_comb begin
        push_c  = bus.push_valid_i & ~full_q & ~bus.flush_i & ~bus.restore_i;
        pop_c   = bus.pop_ready_i & ~empty_q & ~bus.flush_i;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rt_ext  = '0;
        hd_ext  = '0;
        if (bus.flush_i) begin
            head_d  = PW'(INIT);
            tail_d  = PW'(INIT);
            count_d = '0;
        end else begin
            if (pop_c) head_d = ptr_inc(head_q);
            if (bus.restore_i) begin
                // Occupancy is the mod-DEPTH distance from the post-pop head.
                tail_d = bus.restore_tail_i;
                rt_ext = CW'(bus.restore_tail_i);
                hd_ext = CW'(head_d);
                if (rt_ext >= hd_ext) count_d = rt_ext - hd_ext;
                else                  count_d = rt_ext + CW'(DEPTH) - hd_ext;
            end else begin
                if (push_c) tail_d = ptr_inc(tail_q);
                case ({push_c, pop_c})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= PW'(INIT);
            tail_q  <= PW'(INIT);
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign bus.head_o       = head_q;
    assign bus.tail_o       = tail_q;
    assign bus.count_o      = count_q;
    assign bus.full_o       = full_q;
    assign bus.empty_o      = empty_q;
    assign bus.push_ready_o = ~full_q;
    assign bus.pop_valid_o  = ~empty_q;
    assign bus.push_o       = push_c;
    assign bus.pop_o        = pop_c;

`ifdef CIRC_QUEUE_ALMOST_FULL_EN
    logic almost_full_q, almost_full_d;

    always_comb begin
        almost_full_d = (count_d >= CW'(AF_THRESH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) almost_full_q <= 1'b0;
        else         almost_full_q <= almost_full_d;
    end

    assign bus.almost_full_o = almost_full_q;

    // Occupancy bound, and a rollback must never land on a full queue.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (count_q <= CW'(DEPTH));
            assert (!(bus.restore_i && !bus.flush_i) || !full_d);
        end
    end
`endif
endmodule

// File: tb/tb_circ_queue_ptr_ctrl.sv
module tb_circ_queue_ptr_ctrl;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    circ_queue_ptr_ctrl_if #(.DEPTH(16)) if16 ();
    circ_queue_ptr_ctrl_if #(.DEPTH(6))  if6 ();

`ifdef CIRC_QUEUE_ALMOST_FULL_EN
    circ_queue_ptr_ctrl #(.DEPTH(16), .INIT(0), .AF_THRESH(14)) dut16 (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(if16.slave));
    circ_queue_ptr_ctrl #(.DEPTH(6), .INIT(0), .AF_THRESH(4)) dut6 (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(if6.slave));
`else
    circ_queue_ptr_ctrl #(.DEPTH(16), .INIT(0)) dut16 (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(if16.slave));
    circ_queue_ptr_ctrl #(.DEPTH(6), .INIT(0)) dut6 (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(if6.slave));
`endif

    typedef struct {
        logic       pv, pr, fl, rs;
        logic [3:0] rt;
        logic       e_push, e_pop;
        logic [3:0] e_head, e_tail;
        logic [4:0] e_count;
    } vec_t;

    vec_t vecs[64];
    int   n_tab   = 0;
    int   n_vec   = 0;
    int   n_fail  = 0;

    task automatic add(input logic pv, pr, fl, rs, input int rt,
                       input logic ep, eq, input int h, t, c);
        vecs[n_tab].pv = pv; vecs[n_tab].pr = pr;
        vecs[n_tab].fl = fl; vecs[n_tab].rs = rs;
        vecs[n_tab].rt = 4'(rt);
        vecs[n_tab].e_push = ep; vecs[n_tab].e_pop = eq;
        vecs[n_tab].e_head = 4'(h); vecs[n_tab].e_tail = 4'(t);
        vecs[n_tab].e_count = 5'(c);
        n_tab++;
    endtask

    function automatic logic af16();
`ifdef CIRC_QUEUE_ALMOST_FULL_EN
        return if16.almost_full_o;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_af(input logic [4:0] c);
`ifdef CIRC_QUEUE_ALMOST_FULL_EN
        return c >= 5'd14;
`else
        return (c == 5'd31);
`endif
    endfunction

    // Registered view of the 16-deep instance: head,tail,count,full,empty,ready,valid,af
    function automatic logic [17:0] regs16();
        return {if16.head_o, if16.tail_o, if16.count_o, if16.full_o, if16.empty_o,
                if16.push_ready_o, if16.pop_valid_o, af16()};
    endfunction

    function automatic logic [17:0] exp16(input logic [3:0] h, t, input logic [4:0] c);
        logic f, e;
        f = (c == 5'd16);
        e = (c == 5'd0);
        return {h, t, c, f, e, ~f, ~e, exp_af(c)};
    endfunction

    task automatic drive16(input logic pv, pr, fl, rs, input logic [3:0] rt);
        if16.push_valid_i = pv; if16.pop_ready_i = pr;
        if16.flush_i = fl; if16.restore_i = rs; if16.restore_tail_i = rt;
    endtask

    task automatic apply(input int idx);
        logic [19:0] got, exp;
        logic [1:0]  comb;
        @(negedge clk_i);
        drive16(vecs[idx].pv, vecs[idx].pr, vecs[idx].fl, vecs[idx].rs, vecs[idx].rt);
        #1;
        comb = {if16.push_o, if16.pop_o};
        @(posedge clk_i);
        #1;
        got = {comb, regs16()};
        exp = {vecs[idx].e_push, vecs[idx].e_pop,
               exp16(vecs[idx].e_head, vecs[idx].e_tail, vecs[idx].e_count)};
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL vec%0d {push,pop,head,tail,count,full,empty,rdy,vld,af} got=%b exp=%b",
                     idx, got, exp);
        end
    endtask

    initial begin
        int tail_seq[9];
        int head_seq[9];
        logic [9:0] got6, exp6;
        tail_seq = '{1, 2, 3, 4, 5, 0, 1, 2, 3};
        head_seq = '{0, 1, 2, 3, 4, 5, 0, 1, 2};

        drive16(0, 0, 0, 0, 4'd0);
        if6.push_valid_i = 0; if6.pop_ready_i = 0; if6.flush_i = 0;
        if6.restore_i = 0; if6.restore_tail_i = '0;

        // pv pr fl rs rt | push pop head tail count
        for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 0, 1, 0, 0, (i + 1) % 16, i + 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 15);   // full: push refused, pop taken
        add(1, 1, 0, 0, 0, 1, 1, 2, 1, 15);   // push+pop together
        add(1, 1, 1, 1, 3, 0, 0, 0, 0, 0);    // flush beats everything
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);    // pop on empty ignored
        for (int k = 1; k <= 9; k++) add(1, 0, 0, 0, 0, 1, 0, 0, k, k);
        for (int k = 1; k <= 3; k++) add(0, 1, 0, 0, 0, 0, 1, k, 9, 9 - k);
        add(1, 1, 0, 1, 5, 0, 1, 4, 5, 1);    // head3 tail9: restore 5 + pop
        add(0, 0, 0, 1, 9, 0, 0, 4, 9, 5);    // restore only
        add(0, 1, 0, 1, 5, 0, 1, 5, 5, 0);    // restore onto post-pop head -> empty
        add(0, 0, 0, 1, 2, 0, 0, 5, 2, 13);   // wrapped distance
        add(1, 1, 1, 1, 7, 0, 0, 0, 0, 0);    // flush with everything asserted

        #22;
        n_vec++;
        if (regs16() !== exp16(4'd0, 4'd0, 5'd0)) begin
            n_fail++;
            $display("FAIL reset16 got=%b exp=%b", regs16(), exp16(4'd0, 4'd0, 5'd0));
        end
        n_vec++;
        if ({if6.head_o, if6.tail_o, if6.count_o, if6.empty_o} !== {3'd0, 3'd0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset6 got=%b exp=%b",
                     {if6.head_o, if6.tail_o, if6.count_o, if6.empty_o}, 10'b0000000001);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < n_tab; i++) apply(i);
        @(negedge clk_i);
        drive16(0, 0, 0, 0, 4'd0);

        // DEPTH=6: push first, then push+pop every cycle; both pointers wrap 5->0.
        for (int i = 0; i < 9; i++) begin
            logic [1:0] comb;
            @(negedge clk_i);
            if6.push_valid_i = 1'b1;
            if6.pop_ready_i  = (i > 0);
            #1;
            comb = {if6.push_o, if6.pop_o};
            @(posedge clk_i);
            #1;
            got6 = {comb, if6.head_o, if6.tail_o, if6.count_o[1:0]};
            exp6 = {1'b1, (i > 0), 3'(head_seq[i]), 3'(tail_seq[i]), 2'd1};
            n_vec++;
            if (got6 !== exp6 || if6.count_o !== 3'd1) begin
                n_fail++;
                $display("FAIL d6_step%0d {push,pop,head,tail,cnt} got=%b exp=%b cnt=%0d",
                         i, got6, exp6, if6.count_o);
            end
        end
        @(negedge clk_i);
        if6.push_valid_i = 1'b0;
        if6.pop_ready_i  = 1'b0;

        // Asynchronous reset in the middle of a push burst.
        drive16(1, 0, 0, 0, 4'd0);
        repeat (3) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        n_vec++;
        if (regs16() !== exp16(4'd0, 4'd0, 5'd0)) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=%b", regs16(), exp16(4'd0, 4'd0, 5'd0));
        end
        @(negedge clk_i);
        drive16(0, 0, 0, 0, 4'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
